// File: rtl/armleocpu_axi_sram.sv
// AXI4 client-port SRAM with one transaction in flight; reads take priority over writes.
// Out-of-range beats answer DECERR, reserved bursts answer SLVERR, EXOKAY is never returned.
module armleocpu_axi_sram #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  input  logic [ID_WIDTH-1:0]       axi_awid,
  input  logic [ADDR_WIDTH-1:0]     axi_awaddr,
  input  logic [7:0]                axi_awlen,
  input  logic [2:0]                axi_awsize,
  input  logic [1:0]                axi_awburst,

  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  input  logic [DATA_WIDTH-1:0]     axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   axi_wstrb,
  input  logic                      axi_wlast,

  output logic                      axi_bvalid,
  input  logic                      axi_bready,
  output logic [1:0]                axi_bresp,
  output logic [ID_WIDTH-1:0]       axi_bid,

  input  logic                      axi_arvalid,
  output logic                      axi_arready,
  input  logic [ID_WIDTH-1:0]       axi_arid,
  input  logic [ADDR_WIDTH-1:0]     axi_araddr,
  input  logic [7:0]                axi_arlen,
  input  logic [2:0]                axi_arsize,
  input  logic [1:0]                axi_arburst,

  output logic                      axi_rvalid,
  input  logic                      axi_rready,
  output logic [1:0]                axi_rresp,
  output logic                      axi_rlast,
  output logic [DATA_WIDTH-1:0]     axi_rdata,
  output logic [ID_WIDTH-1:0]       axi_rid
);

  localparam int unsigned DATA_STROBES = DATA_WIDTH / 8;
  localparam int unsigned STRB_LOG2    = $clog2(DATA_STROBES);
  localparam int unsigned IDX_W        = $clog2(DEPTH);
  localparam int unsigned CAP          = DEPTH * DATA_STROBES;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    READ_LOAD,
    READ_DATA,
    WRITE_DATA,
    WRITE_RESP
  } state_t;

  state_t                  state;
  logic [ID_WIDTH-1:0]     cur_id;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [7:0]              cur_len;
  logic [2:0]              cur_size;
  logic [1:0]              cur_burst;
  logic [8:0]              beat_cnt;
  logic [1:0]              err_flag;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    in_range_c;
  logic                    rsvd_c;
  logic                    last_beat_c;
  logic [IDX_W-1:0]        word_idx_c;
  logic [ADDR_WIDTH-1:0]   incr_c;
  logic [ADDR_WIDTH-1:0]   seq_c;
  logic [ADDR_WIDTH-1:0]   wrap_mask_c;
  logic [ADDR_WIDTH-1:0]   next_addr_c;
  logic [1:0]              beat_err_c;
  logic                    wr_en_c;

  // AW is only offered while no AR competes for the same idle cycle
  assign axi_awready = axi_arready && !axi_arvalid;

  assign in_range_c  = {1'b0, cur_addr} < (ADDR_WIDTH+1)'(CAP);
  assign rsvd_c      = cur_burst == BURST_RSVD;
  assign last_beat_c = beat_cnt == 9'(cur_len);
  assign word_idx_c  = cur_addr[STRB_LOG2 +: IDX_W];
  assign incr_c      = ADDR_WIDTH'(1) << cur_size;
  assign seq_c       = cur_addr + incr_c;
  assign wrap_mask_c = (ADDR_WIDTH'(9'(cur_len) + 9'd1) << cur_size) - ADDR_WIDTH'(1);

  always_comb begin
    next_addr_c = cur_addr;
    case (cur_burst)
      BURST_INCR: next_addr_c = seq_c;
      BURST_WRAP: next_addr_c = (cur_addr & ~wrap_mask_c) | (seq_c & wrap_mask_c);
      default:    next_addr_c = cur_addr;
    endcase
  end

  // Error flag including the current write beat; SLVERR dominates DECERR
  always_comb begin
    beat_err_c = err_flag;
    if (rsvd_c || (err_flag == RESP_SLVERR)) begin
      beat_err_c = RESP_SLVERR;
    end else if (!in_range_c) begin
      beat_err_c = RESP_DECERR;
    end
  end

  assign wr_en_c = rst_n && (state == WRITE_DATA) && axi_wvalid && axi_wready &&
                   in_range_c && !rsvd_c && (beat_cnt <= 9'(cur_len));

  // Byte-lane writes; array is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int i = 0; i < int'(DATA_STROBES); i++) begin
        if (axi_wstrb[i]) begin
          mem[word_idx_c][i*8 +: 8] <= axi_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      axi_arready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rlast   <= 1'b0;
      axi_bresp   <= RESP_OKAY;
      axi_rresp   <= RESP_OKAY;
      axi_rdata   <= '0;
      axi_bid     <= '0;
      axi_rid     <= '0;
      beat_cnt    <= '0;
      err_flag    <= RESP_OKAY;
      cur_id      <= '0;
      cur_addr    <= '0;
      cur_len     <= '0;
      cur_size    <= '0;
      cur_burst   <= '0;
    end else begin
      case (state)
        IDLE: begin
          axi_arready <= 1'b1;
          if (axi_arvalid && axi_arready) begin
            cur_id      <= axi_arid;
            cur_addr    <= axi_araddr;
            cur_len     <= axi_arlen;
            cur_size    <= axi_arsize;
            cur_burst   <= axi_arburst;
            beat_cnt    <= '0;
            err_flag    <= RESP_OKAY;
            axi_arready <= 1'b0;
            state       <= READ_LOAD;
          end else if (axi_awvalid && axi_awready) begin
            cur_id      <= axi_awid;
            cur_addr    <= axi_awaddr;
            cur_len     <= axi_awlen;
            cur_size    <= axi_awsize;
            cur_burst   <= axi_awburst;
            beat_cnt    <= '0;
            err_flag    <= RESP_OKAY;
            axi_arready <= 1'b0;
            axi_wready  <= 1'b1;
            state       <= WRITE_DATA;
          end
        end
        READ_LOAD: begin
          axi_rdata  <= (in_range_c && !rsvd_c) ? mem[word_idx_c] : '0;
          axi_rresp  <= rsvd_c ? RESP_SLVERR : (in_range_c ? RESP_OKAY : RESP_DECERR);
          axi_rlast  <= last_beat_c;
          axi_rid    <= cur_id;
          axi_rvalid <= 1'b1;
          state      <= READ_DATA;
        end
        READ_DATA: begin
          if (axi_rready) begin
            axi_rvalid <= 1'b0;
            axi_rlast  <= 1'b0;
            if (axi_rlast) begin
              axi_arready <= 1'b1;
              state       <= IDLE;
            end else begin
              cur_addr <= next_addr_c;
              beat_cnt <= beat_cnt + 9'd1;
              state    <= READ_LOAD;
            end
          end
        end
        WRITE_DATA: begin
          if (axi_wvalid) begin
            if (axi_wlast) begin
              axi_wready <= 1'b0;
              axi_bvalid <= 1'b1;
              axi_bid    <= cur_id;
              axi_bresp  <= last_beat_c ? beat_err_c : RESP_SLVERR;
              state      <= WRITE_RESP;
            end else begin
              err_flag <= beat_err_c;
              cur_addr <= next_addr_c;
              if (beat_cnt != '1) begin
                beat_cnt <= beat_cnt + 9'd1;
              end
            end
          end
        end
        WRITE_RESP: begin
          if (axi_bready) begin
            axi_bvalid  <= 1'b0;
            axi_arready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_axi_sram.sv
// Randomised scoreboard bench for armleocpu_axi_sram against a byte-array memory model.
module tb_armleocpu_axi_sram;

  localparam int AW    = 32;
  localparam int IW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int CAP   = DEPTH * 4;

  logic           clk;
  logic           rst_n;
  logic           axi_awvalid, axi_awready;
  logic [IW-1:0]  axi_awid;
  logic [AW-1:0]  axi_awaddr;
  logic [7:0]     axi_awlen;
  logic [2:0]     axi_awsize;
  logic [1:0]     axi_awburst;
  logic           axi_wvalid, axi_wready;
  logic [DW-1:0]  axi_wdata;
  logic [3:0]     axi_wstrb;
  logic           axi_wlast;
  logic           axi_bvalid, axi_bready;
  logic [1:0]     axi_bresp;
  logic [IW-1:0]  axi_bid;
  logic           axi_arvalid, axi_arready;
  logic [IW-1:0]  axi_arid;
  logic [AW-1:0]  axi_araddr;
  logic [7:0]     axi_arlen;
  logic [2:0]     axi_arsize;
  logic [1:0]     axi_arburst;
  logic           axi_rvalid, axi_rready;
  logic [1:0]     axi_rresp;
  logic           axi_rlast;
  logic [DW-1:0]  axi_rdata;
  logic [IW-1:0]  axi_rid;

  armleocpu_axi_sram #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .axi_bid(axi_bid),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rdata(axi_rdata), .axi_rid(axi_rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [31:0]   data;
    logic [1:0]    resp;
    logic          last;
    bit            chk_data;
  } r_exp_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  r_exp_t     rq[$];
  b_exp_t     bq[$];
  logic [7:0] mdl [CAP];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         rready_mode = 1;

  // State of the write burst being driven
  int w_id, w_addr, w_len, w_size, w_burst, w_beat, w_err;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out, got no handshake, expected one", name);
  endfunction

  // Address of the following beat, from burst type and window arithmetic
  function automatic int next_addr(input int a, input int len, input int size, input int burst);
    int incr, total, start;
    incr = 1 << size;
    if (burst == 1) return a + incr;
    if (burst == 2) begin
      total = (len + 1) << size;
      start = (a / total) * total;
      return start + ((a - start + incr) % total);
    end
    return a;
  endfunction

  function automatic logic [31:0] word_at(input int a);
    int b;
    b = (a / 4) * 4;
    return {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
  endfunction

  // Input drivers for ready signals, changed just after the rising edge
  initial begin
    axi_rready = 1'b0;
    axi_bready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rready_mode)
        0:       axi_rready = 1'b1;
        2:       axi_rready = 1'b0;
        default: axi_rready = 1'($urandom_range(0, 1));
      endcase
      axi_bready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops and compares on every R/B handshake, checks R holds while stalled
  initial begin
    bit            hold;
    logic [31:0]   p_data;
    logic [1:0]    p_resp;
    logic          p_last;
    logic [IW-1:0] p_id;
    r_exp_t        re;
    b_exp_t        be;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("r_hold_valid", 64'(axi_rvalid), 64'(1));
          check("r_hold_data", 64'(axi_rdata), 64'(p_data));
          check("r_hold_resp", 64'(axi_rresp), 64'(p_resp));
          check("r_hold_last", 64'(axi_rlast), 64'(p_last));
          check("r_hold_id", 64'(axi_rid), 64'(p_id));
        end
        hold   = axi_rvalid && !axi_rready;
        p_data = axi_rdata;
        p_resp = axi_rresp;
        p_last = axi_rlast;
        p_id   = axi_rid;
        if (axi_rvalid && axi_rready) begin
          if (rq.size() == 0) begin
            check("r_unexpected_beat", 64'(1), 64'(0));
          end else begin
            re = rq.pop_front();
            check("rid", 64'(axi_rid), 64'(re.id));
            check("rresp", 64'(axi_rresp), 64'(re.resp));
            check("rlast", 64'(axi_rlast), 64'(re.last));
            if (re.chk_data) check("rdata", 64'(axi_rdata), 64'(re.data));
          end
        end
        if (axi_bvalid && axi_bready) begin
          if (bq.size() == 0) begin
            check("b_unexpected_resp", 64'(1), 64'(0));
          end else begin
            be = bq.pop_front();
            check("bid", 64'(axi_bid), 64'(be.id));
            check("bresp", 64'(axi_bresp), 64'(be.resp));
          end
        end
      end
    end
  end

  task automatic ar_phase(input int id, input int addr, input int len, input int size, input int burst);
    r_exp_t e;
    int     a;
    bit     got;
    a = addr;
    for (int b = 0; b <= len; b++) begin
      e.id   = IW'(id);
      e.last = (b == len);
      if (burst == 3) begin
        e.resp = 2'd2; e.data = '0; e.chk_data = 1'b0;
      end else if (a < CAP) begin
        e.resp = 2'd0; e.data = word_at(a); e.chk_data = 1'b1;
      end else begin
        e.resp = 2'd3; e.data = '0; e.chk_data = 1'b1;
      end
      rq.push_back(e);
      a = next_addr(a, len, size, burst);
    end
    axi_arid    = IW'(id);
    axi_araddr  = AW'(addr);
    axi_arlen   = 8'(len);
    axi_arsize  = 3'(size);
    axi_arburst = 2'(burst);
    axi_arvalid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = axi_arready;
    end
    if (!got) timeout("ar_handshake");
    @(posedge clk);
    #1 axi_arvalid = 1'b0;
  endtask

  task automatic wait_r(input bit chk_aw);
    int t;
    t = 0;
    while (rq.size() != 0 && t < 400) begin
      @(negedge clk);
      if (chk_aw) check("awready_during_read", 64'(axi_awready), 64'(0));
      t++;
    end
    if (rq.size() != 0) begin
      timeout("r_beats");
      rq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic aw_phase(input int id, input int addr, input int len, input int size, input int burst);
    bit got;
    w_id = id; w_addr = addr; w_len = len; w_size = size; w_burst = burst;
    w_beat = 0; w_err = 0;
    axi_awid    = IW'(id);
    axi_awaddr  = AW'(addr);
    axi_awlen   = 8'(len);
    axi_awsize  = 3'(size);
    axi_awburst = 2'(burst);
    axi_awvalid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      got = axi_awready;
    end
    if (!got) timeout("aw_handshake");
    @(posedge clk);
    #1 axi_awvalid = 1'b0;
  endtask

  // mode 0: fixed data/strobe, 1: random data full strobe, 2: random data random strobe
  task automatic w_beats(input int n, input bit send_last, input int mode,
                         input logic [31:0] fdata, input logic [3:0] fstrb);
    bit     got;
    int     base;
    b_exp_t be;
    for (int k = 0; k < n; k++) begin
      axi_wdata  = (mode == 0) ? fdata : $urandom;
      axi_wstrb  = (mode == 0) ? fstrb : ((mode == 1) ? 4'hF : 4'($urandom_range(0, 15)));
      axi_wlast  = send_last && (k == n - 1);
      axi_wvalid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
        @(negedge clk);
        got = axi_wready;
      end
      if (!got) timeout("w_handshake");
      if (w_burst == 3) begin
        w_err = 2;
      end else if (w_addr >= CAP) begin
        if (w_err != 2) w_err = 3;
      end else if (w_beat <= w_len) begin
        base = (w_addr / 4) * 4;
        for (int i = 0; i < 4; i++)
          if (axi_wstrb[i]) mdl[base+i] = axi_wdata[i*8 +: 8];
      end
      if (axi_wlast) begin
        be.id   = IW'(w_id);
        be.resp = (w_beat != w_len) ? 2'd2 : 2'(w_err);
        bq.push_back(be);
      end
      w_beat++;
      w_addr = next_addr(w_addr, w_len, w_size, w_burst);
      @(posedge clk);
      #1;
      axi_wvalid = 1'b0;
      axi_wlast  = 1'b0;
    end
  endtask

  task automatic wait_b();
    int t;
    t = 0;
    while (bq.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (bq.size() != 0) begin
      timeout("b_resp");
      bq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int id, input int addr, input int len, input int size, input int burst,
                          input int nbeats, input int mode, input logic [31:0] fdata, input logic [3:0] fstrb);
    aw_phase(id, addr, len, size, burst);
    w_beats(nbeats, 1'b1, mode, fdata, fstrb);
    wait_b();
  endtask

  task automatic do_read(input int id, input int addr, input int len, input int size, input int burst);
    ar_phase(id, addr, len, size, burst);
    wait_r(1'b0);
  endtask

  task automatic wait_arready(input string name);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 4 && !got; t++) begin
      @(negedge clk);
      got = axi_arready;
    end
    check(name, 64'(got), 64'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd, r, burst, size, len, addr, nb;
    axi_awvalid = 0; axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0;
    axi_wvalid = 0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 0;
    axi_arvalid = 0; axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = '0; axi_arburst = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 64'(axi_arready), 64'(0));
    check("rst_awready", 64'(axi_awready), 64'(0));
    check("rst_wready", 64'(axi_wready), 64'(0));
    check("rst_rvalid", 64'(axi_rvalid), 64'(0));
    check("rst_bvalid", 64'(axi_bvalid), 64'(0));
    check("rst_rlast", 64'(axi_rlast), 64'(0));
    check("rst_rdata", 64'(axi_rdata), 64'(0));
    check("rst_rresp", 64'(axi_rresp), 64'(0));
    check("rst_bresp", 64'(axi_bresp), 64'(0));
    check("rst_ids", 64'({axi_bid, axi_rid}), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_arready("arready_after_reset");

    // Fill every word so later reads are fully predictable
    for (int i = 0; i < DEPTH / 4; i++) do_write(i, i * 16, 3, 2, 1, 4, 1, '0, '0);

    do_write(5, 'h10, 0, 2, 1, 1, 0, 32'hDEADBEEF, 4'hF);
    do_read(5, 'h10, 0, 2, 1);

    do_read(3, 'h38, 3, 2, 2);

    do_write(2, CAP, 0, 2, 1, 1, 0, 32'h12345678, 4'hF);
    do_read(2, CAP, 0, 2, 1);
    do_read(0, 0, 0, 2, 1);

    // AR and AW together: read wins, AW waits for the read to finish
    axi_awid = 4'd11; axi_awaddr = 32'h24; axi_awlen = 8'd0; axi_awsize = 3'd2; axi_awburst = 2'd1;
    axi_awvalid = 1'b1;
    ar_phase(4, 'h18, 1, 2, 1);
    wait_r(1'b1);
    aw_phase(11, 'h24, 0, 2, 1);
    w_beats(1, 1'b1, 0, 32'hA5A5A5A5, 4'hF);
    wait_b();
    do_read(11, 'h24, 0, 2, 1);

    do_write(6, 'h10, 0, 2, 1, 1, 0, 32'hCAFEF00D, 4'h0);
    do_read(6, 'h10, 0, 2, 1);
    do_write(6, 'h10, 0, 2, 1, 1, 0, 32'h11223344, 4'h3);
    do_read(6, 'h10, 0, 2, 1);

    // R channel stalled for five cycles
    rready_mode = 2;
    ar_phase(7, 'h20, 0, 2, 1);
    repeat (6) @(negedge clk);
    rready_mode = 0;
    wait_r(1'b0);
    rready_mode = 1;

    // Reset in the middle of a read burst
    ar_phase(8, 0, 7, 2, 1);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rvalid_after_reset", 64'(axi_rvalid), 64'(0));
    rq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_arready("arready_after_read_abort");

    // Reset in the middle of a write burst: only the two accepted beats land
    aw_phase(9, 'h80, 3, 2, 1);
    w_beats(2, 1'b0, 1, '0, '0);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_arready("arready_after_write_abort");
    do_read(9, 'h80, 3, 2, 1);

    for (int it = 0; it < 80; it++) begin
      rd    = $urandom_range(0, 1);
      r     = $urandom_range(0, 15);
      burst = (r < 2) ? 0 : (r < 12) ? 1 : (r < 15) ? 2 : 3;
      size  = $urandom_range(0, 2);
      if (burst == 2) len = (2 << $urandom_range(0, 3)) - 1;
      else            len = $urandom_range(0, 7);
      addr  = $urandom_range(0, CAP + 63) & ~((1 << size) - 1);
      if (rd == 1) begin
        do_read($urandom_range(0, 15), addr, len, size, burst);
      end else begin
        nb = len + 1;
        if ($urandom_range(0, 9) == 0) nb = (len > 0 && $urandom_range(0, 1) == 1) ? len : len + 2;
        do_write($urandom_range(0, 15), addr, len, size, burst, nb, 2, '0, '0);
      end
    end

    // Read the whole array back
    for (int i = 0; i < DEPTH / 16; i++) do_read(i, i * 64, 15, 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/armleocpu_axi_sram.md
ARMLEOCPU_AXI_SRAM -- requirements
Module: armleocpu_axi_sram

Purpose: AXI4 client-port memory directly downstream of the exclusive monitor; consumes its memory_axi_* host port.

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 Parameter ID_WIDTH, default 4, AXI ID width.
REQ-003 Parameter DATA_WIDTH, default 32, data width (32 or 64); DATA_STROBES = DATA_WIDTH/8.
REQ-004 Parameter DEPTH, default 1024, number of DATA_WIDTH words (power of two); byte capacity CAP = DEPTH*DATA_STROBES.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 axi_awvalid in 1, axi_awready out 1, axi_awid in ID_WIDTH, axi_awaddr in ADDR_WIDTH, axi_awlen in 8, axi_awsize in 3, axi_awburst in 2: write address channel.
REQ-008 axi_wvalid in 1, axi_wready out 1, axi_wdata in DATA_WIDTH, axi_wstrb in DATA_STROBES, axi_wlast in 1: write data channel.
REQ-009 axi_bvalid out 1, axi_bready in 1, axi_bresp out 2, axi_bid out ID_WIDTH: write response channel.
REQ-010 axi_arvalid in 1, axi_arready out 1, axi_arid in ID_WIDTH, axi_araddr in ADDR_WIDTH, axi_arlen in 8, axi_arsize in 3, axi_arburst in 2: read address channel.
REQ-011 axi_rvalid out 1, axi_rready in 1, axi_rresp out 2, axi_rlast out 1, axi_rdata out DATA_WIDTH, axi_rid out ID_WIDTH: read data channel.

Function
REQ-012 FSM states SHALL be IDLE, READ_LOAD, READ_DATA, WRITE_DATA, WRITE_RESP; one transaction outstanding at a time.
REQ-013 axi_arready and axi_awready SHALL be 1 only in IDLE; IDLE with both valids SHALL accept AR only (read priority).
REQ-014 AR/AW handshake SHALL latch id, addr, len, size, burst, clear beat counter and error flag; AR -> READ_LOAD, AW -> WRITE_DATA.
REQ-015 Word index = addr[log2(CAP)-1 : log2(DATA_STROBES)]; beat out of range when addr >= CAP.
REQ-016 Next-beat address: FIXED unchanged; INCR += 1<<size; WRAP increments then wraps within aligned window of (len+1)<<size bytes; burst 2'b11 reserved.
REQ-017 READ_LOAD: one cycle reading array into registered axi_rdata, then READ_DATA; 2-cycle minimum per beat.
REQ-018 READ_DATA: axi_rvalid=1, rdata/rresp/rlast/rid stable until axi_rready; rid = latched arid.
REQ-019 axi_rresp per beat: OKAY(0) in range, DECERR(3) out of range with rdata=0, SLVERR(2) all beats for reserved burst.
REQ-020 axi_rlast SHALL be 1 exactly when beat counter == latched len.
REQ-021 R handshake with rlast -> IDLE; otherwise advance address, counter+1, -> READ_LOAD.
REQ-022 WRITE_DATA: axi_wready=1; each W handshake writes bytes with wstrb bit set; no write if out of range or reserved burst; sets DECERR/SLVERR flag accordingly (SLVERR dominates).
REQ-023 Handshake with wlast -> WRITE_RESP; flag SLVERR if beat count != len+1; beats beyond len SHALL not write.
REQ-024 WRITE_RESP: axi_bvalid=1, bid = latched awid, bresp = flag or OKAY; held until axi_bready, then IDLE.
REQ-025 Block SHALL never return EXOKAY; wstrb=0 beats (masked exclusive-fail writes) SHALL complete with OKAY and leave memory unchanged.
REQ-026 Array contents SHALL persist across reset; not initialised.

Reset
REQ-027 rst_n=0 at a clock edge: state IDLE; awready, arready, wready, bvalid, rvalid, rlast =0; bresp, rresp, rdata, bid, rid =0; counter and flags cleared.
REQ-028 Reset mid-burst SHALL abort the transaction without further array writes; first post-reset cycle is IDLE.

Verification
REQ-029 AW addr 0x10 len 0 INCR size 2, W 0xDEADBEEF strb 0xF -> bresp 0 bid=awid; then AR same -> rdata 0xDEADBEEF, rresp 0, rlast 1.
REQ-030 AR addr 0x38 len 3 WRAP size 2 -> beats read 0x38,0x3C,0x30,0x34; rlast on 4th only.
REQ-031 AW addr CAP len 0, W any -> bresp 3, memory unchanged; AR addr CAP -> rresp 3, rdata 0.
REQ-032 AR and AW valid same cycle in IDLE -> AR accepted, awready 0 until read's rlast handshake done.
REQ-033 Write wstrb 0x0 to 0x10 -> bresp 0, subsequent read returns previous value; wstrb 0x3 write -> only bytes 0-1 change.
REQ-034 rready held 0 five cycles -> rvalid/rdata stable; rst_n=0 mid-burst -> rvalid 0 next cycle, arready 1 after release.
